fft_frame_ctrl: RTL

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

---
 rtl/fft_frame_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fft_frame_ctrl.sv
// Frame-level flow controller in front of the stage-0 FFT datapath: accepts 16-sample
// beats, bounds the number of frames in flight and flags stream errors. Samples pass as raw bits.
module fft_frame_ctrl #(
  parameter int NUM_BEATS    = 32,
  parameter int MAX_INFLIGHT = 2,
  parameter int DW           = 9,
  localparam int BW = $clog2(NUM_BEATS),
  localparam int IW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 frame_en,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [15:0][DW-1:0]  s_din_i,
  input  logic [15:0][DW-1:0]  s_din_q,
  output logic                 din_valid,
  output logic [15:0][DW-1:0]  din_i,
  output logic [15:0][DW-1:0]  din_q,
  output logic [BW-1:0]        beat_idx,
  output logic                 frame_start,
  input  logic                 valid_out,
  output logic                 frame_done,
  output logic [IW-1:0]        inflight,
  output logic                 busy,
  input  logic                 err_clr,
  output logic                 err_gap,
  output logic                 err_spur
);

  typedef enum logic [0:0] {IDLE = 1'b0, LOAD = 1'b1} state_t;

  localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_BEATS - 1);
  localparam logic [IW-1:0] MAX_IF    = IW'(MAX_INFLIGHT);

  state_t              state_r, state_s;
  logic [BW-1:0]       in_cnt_r, in_cnt_s;
  logic [BW-1:0]       out_cnt_r, out_cnt_s;
  logic [IW-1:0]       inflight_r, inflight_s;
  logic                xfer_s, first_s, last_s, count_out_s, done_s;
  logic                gap_set_s, spur_set_s, err_gap_s, err_spur_s;
  logic                err_gap_r, err_spur_r;
  logic                din_valid_r, frame_start_r, frame_done_r, busy_r;
  logic [BW-1:0]       beat_idx_r;
  logic [15:0][DW-1:0] din_i_r, din_q_r;

  // Next-state, counter and error-flag logic.
  always_comb begin
    xfer_s      = s_valid & (state_r == LOAD);
    first_s     = xfer_s & (in_cnt_r == {BW{1'b0}});
    last_s      = xfer_s & (in_cnt_r == LAST_BEAT);
    count_out_s = valid_out & (inflight_r != {IW{1'b0}});
    done_s      = count_out_s & (out_cnt_r == LAST_BEAT);
    gap_set_s   = (state_r == LOAD) & ~s_valid & (in_cnt_r != {BW{1'b0}});
    spur_set_s  = valid_out & (inflight_r == {IW{1'b0}});

    inflight_s = inflight_r;
    case ({first_s, done_s})
      2'b10:   inflight_s = inflight_r + IW'(1'b1);
      2'b01:   inflight_s = inflight_r - IW'(1'b1);
      default: inflight_s = inflight_r;
    endcase

    // A frame is only left at its last beat, so frame_en dropping never truncates it.
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (frame_en && (inflight_r < MAX_IF)) state_s = LOAD;
        else                                   state_s = IDLE;
      end
      LOAD: begin
        if (last_s && !(frame_en && (inflight_s < MAX_IF))) state_s = IDLE;
        else                                                  state_s = LOAD;
      end
      default: state_s = IDLE;
    endcase

    in_cnt_s = in_cnt_r;
    if (state_r == IDLE) in_cnt_s = {BW{1'b0}};
    else if (xfer_s)     in_cnt_s = last_s ? {BW{1'b0}} : in_cnt_r + BW'(1'b1);
    else                 in_cnt_s = in_cnt_r;

    out_cnt_s = out_cnt_r;
    if (count_out_s) out_cnt_s = done_s ? {BW{1'b0}} : out_cnt_r + BW'(1'b1);
    else             out_cnt_s = out_cnt_r;

    // Setting an error wins over clearing it in the same cycle.
    err_gap_s = err_gap_r;
    if (gap_set_s)    err_gap_s = 1'b1;
    else if (err_clr) err_gap_s = 1'b0;
    else              err_gap_s = err_gap_r;

    err_spur_s = err_spur_r;
    if (spur_set_s)   err_spur_s = 1'b1;
    else if (err_clr) err_spur_s = 1'b0;
    else              err_spur_s = err_spur_r;
  end

  // Control state, counters and sticky error flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= IDLE;
      in_cnt_r   <= {BW{1'b0}};
      out_cnt_r  <= {BW{1'b0}};
      inflight_r <= {IW{1'b0}};
      err_gap_r  <= 1'b0;
      err_spur_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      in_cnt_r   <= in_cnt_s;
      out_cnt_r  <= out_cnt_s;
      inflight_r <= inflight_s;
      err_gap_r  <= err_gap_s;
      err_spur_r <= err_spur_s;
    end
  end

  // Registered beat handoff and status pulses toward the datapath.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      din_valid_r   <= 1'b0;
      din_i_r       <= {(16*DW){1'b0}};
      din_q_r       <= {(16*DW){1'b0}};
      beat_idx_r    <= {BW{1'b0}};
      frame_start_r <= 1'b0;
      frame_done_r  <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      din_valid_r   <= xfer_s;
      frame_start_r <= first_s;
      frame_done_r  <= done_s;
      busy_r        <= (state_s == LOAD) | (inflight_s != {IW{1'b0}});
      if (xfer_s) begin
        din_i_r    <= s_din_i;
        din_q_r    <= s_din_q;
        beat_idx_r <= in_cnt_r;
      end else begin
        din_i_r    <= din_i_r;
        din_q_r    <= din_q_r;
        beat_idx_r <= beat_idx_r;
      end
    end
  end

  assign s_ready     = (state_r == LOAD);
  assign din_valid   = din_valid_r;
  assign din_i       = din_i_r;
  assign din_q       = din_q_r;
  assign beat_idx    = beat_idx_r;
  assign frame_start = frame_start_r;
  assign frame_done  = frame_done_r;
  assign inflight    = inflight_r;
  assign busy        = busy_r;
  assign err_gap     = err_gap_r;
  assign err_spur    = err_spur_r;

endmodule
